// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI serial-clock generator.
//   spi_gen_state_t : burst sequencer states (IDLE -> RUN -> FIN -> IDLE)
//   SPI_MODE0..3    : SPI modes encoded as {cpol, cpha}
//   spi_mode()      : packs cpol/cpha into the mode encoding
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } spi_gen_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// ---------------------------------------------------------------------------
// spi_half_period_cnt
// Loadable down-counter that times one sclk half-period. A load captures both
// the current count and the reload value; while enabled the count walks down
// to zero, tick_o fires for that cycle and the count reloads automatically,
// so ticks repeat every (load_val_i + 1) enabled cycles.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   load_i      : capture load_val_i as count and reload value
//   load_val_i  : half-period minus one
//   en_i        : count enable
//   tick_o      : count reached zero this cycle (only while enabled)
// ---------------------------------------------------------------------------
module spi_half_period_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] rld_q, rld_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        if (load_i) begin
            cnt_d = load_val_i;
            rld_d = load_val_i;
        end else if (en_i) begin
            cnt_d = tick_o ? rld_q : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// SPI serial-clock generator. On an accepted start it latches the divider,
// bit count and mode, then produces 2*nbits sclk toggles spaced div+1 clk
// cycles apart, with one-cycle lead/trail strobes aligned to the cycle in
// which sclk first shows its new level. sample_en/shift_en map those strobes
// to the capture/launch points for the latched cpha.
//   clk_i, rst_i   : system clock, synchronous active-high reset
//   start_i        : burst request, accepted when not busy (IDLE or FIN)
//   div_i          : half-period minus one (latched on accept)
//   nbits_i        : bits per burst, 0 gives an immediate done (latched)
//   cpol_i, cpha_i : SPI mode (latched on accept)
//   busy_o         : burst in progress (RUN)
//   done_o         : one-cycle end-of-burst pulse (FIN)
//   sclk_o         : registered serial clock
//   lead_edge_o    : sclk just left its idle level
//   trail_edge_o   : sclk just returned to its idle level
//   sample_en_o    : capture strobe for the shift register
//   shift_en_o     : launch strobe for the shift register
// ---------------------------------------------------------------------------
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] nbits_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic             sample_en_o,
    output logic             shift_en_o
);

    // One extra bit so 2*nbits never overflows at the maximum burst length.
    localparam logic [CNT_W:0] TGL_ONE = {{CNT_W{1'b0}}, 1'b1};

    spi_gen_state_t state_q, state_d;
    logic [1:0]     mode_q, mode_d;      // {cpol, cpha} of the current burst
    logic [CNT_W:0] tgl_q, tgl_d;        // sclk toggles still to produce
    logic           sclk_q, sclk_d;
    logic           lead_q, lead_d;
    logic           trail_q, trail_d;

    logic accept;
    logic tick;

    // FIN accepts a new start as well, giving back-to-back bursts.
    assign accept = start_i && (state_q != RUN);

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (div_i),
        .en_i       (state_q == RUN),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgl_d   = tgl_q;
        sclk_d  = sclk_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start_i) begin
                    mode_d  = spi_mode(cpol_i, cpha_i);
                    tgl_d   = {nbits_i, 1'b0};
                    // Idle level follows cpol only at accept time.
                    sclk_d  = cpol_i;
                    state_d = (nbits_i == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    tgl_d  = tgl_q - TGL_ONE;
                    // tgl_q starts even (2*nbits), so an even remaining count
                    // marks an odd-numbered toggle, i.e. the leading edge.
                    if (!tgl_q[0]) begin
                        lead_d = 1'b1;
                    end else begin
                        trail_d = 1'b1;
                    end
                    if (tgl_q == TGL_ONE) begin
                        state_d = FIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= SPI_MODE0;
            tgl_q   <= '0;
            sclk_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tgl_q   <= tgl_d;
            sclk_q  <= sclk_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == FIN);
    assign sclk_o       = sclk_q;
    assign lead_edge_o  = lead_q;
    assign trail_edge_o = trail_q;
    // cpha=0 captures on the leading edge, cpha=1 on the trailing edge.
    assign sample_en_o  = mode_q[0] ? trail_q : lead_q;
    assign shift_en_o   = mode_q[0] ? lead_q  : trail_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
module tb_spi_sclk_gen;
    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [DIV_W-1:0] div_i = '0;
    logic [CNT_W-1:0] nbits_i = '0;
    logic             cpol_i = 1'b0;
    logic             cpha_i = 1'b0;
    logic busy_o, done_o, sclk_o, lead_edge_o, trail_edge_o, sample_en_o, shift_en_o;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  meas_on = 1'b0;
    time rise_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .div_i(div_i),
        .nbits_i(nbits_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .busy_o(busy_o), .done_o(done_o), .sclk_o(sclk_o),
        .lead_edge_o(lead_edge_o), .trail_edge_o(trail_edge_o),
        .sample_en_o(sample_en_o), .shift_en_o(shift_en_o)
    );

    // Governing event from a given edge onward: a reset or an accepted burst.
    typedef struct {int k; bit rst; int d; int n; bit pol; bit pha;} gov_t;
    // Expected strobe cycle: {sclk, lead, trail, sample, shift, done}.
    typedef struct {int e; logic [5:0] v;} ev_t;
    gov_t gov_q[$];
    ev_t  ev_q[$];

    function automatic int gov_at(int e);
        for (int i = gov_q.size() - 1; i >= 0; i--)
            if (gov_q[i].k <= e) return i;
        return -1;
    endfunction

    function automatic bit busy_at(int e);
        int g;
        g = gov_at(e);
        if (g < 0 || gov_q[g].rst) return 1'b0;
        return (gov_q[g].n > 0) && (e < gov_q[g].k + 2 * gov_q[g].n * (gov_q[g].d + 1));
    endfunction

    function automatic bit sclk_at(int e);
        int g, t;
        g = gov_at(e);
        if (g < 0 || gov_q[g].rst) return 1'b0;
        t = (e - gov_q[g].k) / (gov_q[g].d + 1);
        if (t > 2 * gov_q[g].n) t = 2 * gov_q[g].n;
        return gov_q[g].pol ^ t[0];
    endfunction

    // Inputs presented for edge k: decide acceptance and queue expected strobes.
    function automatic void model_edge(int k, bit st, bit rs, int dv, int nb, bit pl, bit ph);
        gov_t g;
        ev_t  v;
        bit   ld;
        if (rs) begin
            g = '{k: k, rst: 1'b1, d: 0, n: 0, pol: 1'b0, pha: 1'b0};
            gov_q.push_back(g);
            while (ev_q.size() > 0 && ev_q[$].e >= k) void'(ev_q.pop_back());
        end else if (st && !busy_at(k - 1)) begin
            g = '{k: k, rst: 1'b0, d: dv, n: nb, pol: pl, pha: ph};
            gov_q.push_back(g);
            if (nb == 0) begin
                v.e = k;
                v.v = {pl, 5'b00001};
                ev_q.push_back(v);
            end
            for (int j = 1; j <= 2 * nb; j++) begin
                ld  = (j % 2 == 1);
                v.e = k + j * (dv + 1);
                v.v = {pl ^ ld, ld, !ld, ph ? !ld : ld, ph ? ld : !ld, j == 2 * nb};
                ev_q.push_back(v);
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: per-cycle level checks plus scoreboard pop on strobe cycles.
    always @(negedge clk) begin : mon
        int e;
        logic [5:0] got;
        e = cyc;
        if (gov_at(e) >= 0) begin
            check("busy", {31'd0, busy_o}, {31'd0, busy_at(e)});
            check("sclk", {31'd0, sclk_o}, {31'd0, sclk_at(e)});
            got = {sclk_o, lead_edge_o, trail_edge_o, sample_en_o, shift_en_o, done_o};
            if (ev_q.size() > 0 && ev_q[0].e == e) begin
                check("strobes", {26'd0, got}, {26'd0, ev_q[0].v});
                void'(ev_q.pop_front());
            end else if (got[4:0] != '0) begin
                check("spurious_strobe", {27'd0, got[4:0]}, 32'd0);
            end
        end
    end

    always @(posedge sclk_o) if (meas_on) rise_t.push_back($time);

    task automatic step(input bit st, input bit rs, input int dv, input int nb,
                        input bit pl, input bit ph);
        @(posedge clk);
        #1;
        start_i = st;
        rst_i   = rs;
        div_i   = DIV_W'(dv);
        nbits_i = CNT_W'(nb);
        cpol_i  = pl;
        cpha_i  = ph;
        model_edge(cyc + 1, st, rs, dv, nb, pl, ph);
    endtask

    // Idle cycles with noise on the latched inputs; none of it may matter.
    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic burst(input int dv, input int nb, input bit pl, input bit ph);
        step(1'b1, 1'b0, dv, nb, pl, ph);
        idle(2 * nb * (dv + 1) + 2);
    endtask

    initial begin
        gov_t g0;
        g0 = '{k: 1, rst: 1'b1, d: 0, n: 0, pol: 1'b0, pha: 1'b0};
        gov_q.push_back(g0);
        step(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        idle(3);

        // Mode 0, div=4, nbits=8: sclk period 10 clk, 8 rising edges.
        meas_on = 1'b1;
        burst(4, 8, 1'b0, 1'b0);
        meas_on = 1'b0;
        check("rise_count", rise_t.size(), 32'd8);
        for (int i = 1; i < rise_t.size(); i++)
            check("sclk_period", 32'(rise_t[i] - rise_t[i-1]), 32'd100);

        burst(1, 3, 1'b1, 1'b1);      // mode 3
        burst(0, 1, 1'b0, 1'b0);      // fastest clock, single bit
        burst(2, 0, 1'b1, 1'b0);      // empty burst

        // start held high: back-to-back bursts, div noise only while busy.
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, busy_at(cyc) ? int'($urandom_range(0, 255)) : 2, 2, 1'b0, 1'b1);
        idle(16);

        // Reset right after the third toggle, then a fresh burst.
        step(1'b1, 1'b0, 1, 4, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 0, 0, 1'b1, 1'b1);
        idle(2);
        burst(1, 4, 1'b0, 1'b0);

        // Random traffic: gaps, ignored starts, occasional reset.
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(90);

        check("drain", ev_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised, synthesizable SPI serial-clock generator. Derives `sclk` from the system clock with a runtime-programmable integer divider, supports all four CPOL/CPHA modes, and emits a burst of N bit-clocks per transaction. Sits between the SPI master's control FSM and its shift register: it supplies `sclk` plus single-cycle `sample_en`/`shift_en` strobes that tell the datapath when to capture and when to launch.

## Interface
- `DIV_W`, 8: width of divider input; half-period = `div`+1 clk cycles.
- `CNT_W`, 6: width of bit-count input; max burst 2^CNT_W−1 bits.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset; one clock, reset is synchronous and active-high.
- `start` input 1: request a burst; accepted only when `busy`=0.
- `div` input DIV_W: half-period minus one, latched on accept.
- `nbits` input CNT_W: bits in burst, latched on accept.
- `cpol` input 1: idle level of `sclk`, latched on accept.
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- `busy` output 1: burst in progress.
- `done` output 1: one-cycle pulse at end of burst.
- `sclk` output 1: serial clock, registered.
- `lead_edge` output 1: pulse in cycle `sclk` first shows non-idle level of a bit.
- `trail_edge` output 1: pulse in cycle `sclk` returns to idle level.
- `sample_en` output 1: = `lead_edge` if cpha=0, else `trail_edge`.
- `shift_en` output 1: = `trail_edge` if cpha=0, else `lead_edge`.

## Operation
- States: IDLE, RUN, FIN. Reset → IDLE; `busy`,`done`,edge strobes = 0; `sclk` = 0 (cpol register cleared).
- IDLE: `sclk` = latched cpol. `start`=1 → latch div/nbits/cpol/cpha, load half-period counter with `div`, load toggle counter with 2·nbits, → RUN. If `nbits`=0 → FIN directly, no edges.
- RUN: counter decrements each cycle; at 0 it reloads `div`, `sclk` toggles, toggle counter decrements, matching strobe fires. Odd toggle = lead, even = trail. On last toggle → FIN.
- FIN: one cycle; `done`=1, `busy`=0, → IDLE. `start` in FIN is accepted (back-to-back bursts, one-cycle gap).
- `start` while RUN ignored; inputs changing mid-burst have no effect.
- `cpol` change in IDLE with no start: `sclk` does not change until next accepted start (idle level updates at accept).
- `rst` mid-burst: next cycle IDLE, `sclk`=0, no `done`.
- Arithmetic: toggle counter is CNT_W+1 bits; no overflow for nbits=2^CNT_W−1.

## Timing
- Start sampled at edge k → `busy`=1 after edge k.
- First `sclk` toggle after edge k+div+1; toggle j after edge k+j·(div+1), j=1..2·nbits.
- Last toggle and transition to FIN at same edge; `done` high the following cycle; `busy` low from the edge of the last toggle.
- Strobes coincident with the cycle `sclk` shows the new level; one clk wide.
- div=0 → `sclk` = clk/2, strobes on consecutive cycles alternating lead/trail.

## Structure
- Package `spi_pkg`: state enum `spi_gen_state_t` {IDLE, RUN, FIN}; mode constants `SPI_MODE0..3` as {cpol,cpha}.
- Sub-module `spi_half_period_cnt` (loadable down-counter, DIV_W wide, `tick` at zero with auto-reload); top holds FSM, toggle counter, sclk and strobe registers.

## Test plan
- clk 100 MHz, div=4, nbits=8, mode0: bench measures posedge-to-posedge `sclk` = 100 ns, exactly 8 rising edges, `done` once, 8 `sample_en` on rising `sclk`.
- Mode3 (cpol=1,cpha=1), div=1, nbits=3: `sclk` idles 1, 6 toggles 2 clk apart, `sample_en` on rising (trailing) edges, ends at 1.
- div=0, nbits=1: `sclk` high one cycle, low next, `done` following cycle; `busy` high exactly 2 cycles.
- nbits=0: `done` after one cycle, `sclk` never toggles.
- `start` held high continuously, nbits=2, div=2: bursts repeat with one FIN cycle between; mid-burst `div` change ignored.
- `rst` asserted after third toggle: `sclk`=0, `busy`=0 next cycle, no `done`; fresh start then works normally.
